// File: rtl/bram_dp.sv
// Dual-port block RAM: port A read/write, port B read-only, with a clear engine that fills the array after reset or on request.
// Optional macro BRAM_DP_PARITY_EN adds one even-parity bit per word, with error injection on port A writes.
module bram_dp #(
  parameter int                DATA_W   = 10,
  parameter int                ADDR_W   = 6,
  parameter int                DEPTH    = 64,
  parameter int                RDW_MODE = 0,
  parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_a_en,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  input  logic              i_a_pinj,
  output logic [DATA_W-1:0] o_a_rdata,
  output logic              o_a_rvalid,
  output logic              o_a_oor,
  output logic              o_a_perr,
  input  logic              i_b_en,
  input  logic [ADDR_W-1:0] i_b_addr,
  output logic [DATA_W-1:0] o_b_rdata,
  output logic              o_b_rvalid,
  output logic              o_b_oor,
  output logic              o_b_perr,
  output logic              o_busy
);

`ifdef BRAM_DP_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int WORD_W = DATA_W;
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   ptr;
  logic [WORD_W-1:0]   mem [DEPTH];
  logic [WORD_W-1:0]   a_word, clr_word, a_q, b_q;
  logic                idle, a_acc, b_acc, a_in, b_in, a_wr, a_fwd, b_fwd;

`ifdef BRAM_DP_PARITY_EN
  // Stored parity is even; injection flips it so the next read flags an error.
  assign a_word   = {(^i_a_wdata) ^ i_a_pinj, i_a_wdata};
  assign clr_word = {^CLR_VAL, CLR_VAL};
`else
  logic unused_pinj;
  assign unused_pinj = i_a_pinj;
  assign a_word      = i_a_wdata;
  assign clr_word    = CLR_VAL;
`endif

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (ptr == LAST) state_next = IDLE;
      IDLE:    if (i_clr) state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CLEAR;
      ptr    <= '0;
      o_busy <= 1'b1;
    end else begin
      state  <= state_next;
      o_busy <= (state_next == CLEAR);
      ptr    <= (state == CLEAR && state_next == CLEAR) ? ptr + 1'b1 : '0;
    end
  end

  assign idle  = (state == IDLE);
  assign a_acc = idle & i_a_en & ~i_clr;
  assign b_acc = idle & i_b_en;
  assign a_in  = ({1'b0, i_a_addr} < DEPTH_L);
  assign b_in  = ({1'b0, i_b_addr} < DEPTH_L);
  assign a_wr  = a_acc & i_a_we & a_in;
  assign a_fwd = (RDW_MODE == 1) & i_a_we;
  assign b_fwd = (RDW_MODE == 1) & a_wr & (i_b_addr == i_a_addr);
  assign a_q   = a_fwd ? a_word : mem[i_a_addr];
  assign b_q   = b_fwd ? a_word : mem[i_b_addr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[ptr] <= clr_word;
      else if (a_wr)      mem[i_a_addr] <= a_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_a_rdata  <= '0;
      o_a_rvalid <= 1'b0;
      o_a_oor    <= 1'b0;
      o_a_perr   <= 1'b0;
    end else begin
      o_a_rvalid <= a_acc;
      o_a_oor    <= a_acc & ~a_in;
      o_a_perr   <= a_acc & a_in & PAR_EN & (^a_q);
      if (a_acc) o_a_rdata <= a_in ? a_q[DATA_W-1:0] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_b_rdata  <= '0;
      o_b_rvalid <= 1'b0;
      o_b_oor    <= 1'b0;
      o_b_perr   <= 1'b0;
    end else begin
      o_b_rvalid <= b_acc;
      o_b_oor    <= b_acc & ~b_in;
      o_b_perr   <= b_acc & b_in & PAR_EN & (^b_q);
      if (b_acc) o_b_rdata <= b_in ? b_q[DATA_W-1:0] : '0;
    end
  end

endmodule

// File: tb/tb_bram_dp.sv
// Bench for bram_dp: two instances (64 words old-data, 48 words new-data) share stimulus and are checked against an array model.
`timescale 1ns/1ps
module tb_bram_dp;
  localparam int DW = 10;
  localparam int AW = 6;
`ifdef BRAM_DP_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_clr = 1'b0, i_a_en = 1'b0, i_a_we = 1'b0, i_a_pinj = 1'b0, i_b_en = 1'b0;
  logic [AW-1:0] i_a_addr = '0, i_b_addr = '0;
  logic [DW-1:0] i_a_wdata = '0;

  logic [DW-1:0] a_rdata [2];
  logic [DW-1:0] b_rdata [2];
  logic [1:0] a_rvalid, a_oor, a_perr, b_rvalid, b_oor, b_perr, busy;

  always #5 clk = ~clk;

  bram_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(64), .RDW_MODE(0), .CLR_VAL(10'h000)) u_dut0 (
    .clk(clk), .rst(rst), .i_clr(i_clr),
    .i_a_en(i_a_en), .i_a_we(i_a_we), .i_a_addr(i_a_addr), .i_a_wdata(i_a_wdata), .i_a_pinj(i_a_pinj),
    .o_a_rdata(a_rdata[0]), .o_a_rvalid(a_rvalid[0]), .o_a_oor(a_oor[0]), .o_a_perr(a_perr[0]),
    .i_b_en(i_b_en), .i_b_addr(i_b_addr),
    .o_b_rdata(b_rdata[0]), .o_b_rvalid(b_rvalid[0]), .o_b_oor(b_oor[0]), .o_b_perr(b_perr[0]),
    .o_busy(busy[0]));

  bram_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(48), .RDW_MODE(1), .CLR_VAL(10'h1A5)) u_dut1 (
    .clk(clk), .rst(rst), .i_clr(i_clr),
    .i_a_en(i_a_en), .i_a_we(i_a_we), .i_a_addr(i_a_addr), .i_a_wdata(i_a_wdata), .i_a_pinj(i_a_pinj),
    .o_a_rdata(a_rdata[1]), .o_a_rvalid(a_rvalid[1]), .o_a_oor(a_oor[1]), .o_a_perr(a_perr[1]),
    .i_b_en(i_b_en), .i_b_addr(i_b_addr),
    .o_b_rdata(b_rdata[1]), .o_b_rvalid(b_rvalid[1]), .o_b_oor(b_oor[1]), .o_b_perr(b_perr[1]),
    .o_busy(busy[1]));

  // Reference model: per-instance word array, injected-parity flags and remaining clear cycles.
  int unsigned   depth_m [2];
  int unsigned   rdw_m   [2];
  logic [DW-1:0] clr_m   [2];
  logic [DW-1:0] mem_m   [2][64];
  bit            bad_m   [2][64];
  int unsigned   busy_left [2];
  logic [DW-1:0] e_ard [2], e_brd [2];
  bit e_arv [2], e_aoor [2], e_aperr [2], e_brv [2], e_boor [2], e_bperr [2], e_busy [2];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int unsigned dep = depth_m[k];
      int unsigned aa = i_a_addr;
      int unsigned ba = i_b_addr;
      bit a_acc = i_a_en && !i_clr;
      bit a_wr = a_acc && i_a_we && (aa < dep);
      if (rst) begin
        busy_left[k] = dep;
        e_busy[k] = 1'b1;
        e_ard[k] = '0; e_brd[k] = '0;
        e_arv[k] = 0; e_aoor[k] = 0; e_aperr[k] = 0;
        e_brv[k] = 0; e_boor[k] = 0; e_bperr[k] = 0;
      end else if (busy_left[k] != 0) begin
        mem_m[k][dep - busy_left[k]] = clr_m[k];
        bad_m[k][dep - busy_left[k]] = 1'b0;
        busy_left[k]--;
        e_busy[k] = (busy_left[k] != 0);
        e_arv[k] = 0; e_aoor[k] = 0; e_aperr[k] = 0;
        e_brv[k] = 0; e_boor[k] = 0; e_bperr[k] = 0;
      end else begin
        e_arv[k] = a_acc; e_aoor[k] = 0; e_aperr[k] = 0;
        if (a_acc) begin
          if (aa >= dep) begin
            e_ard[k] = '0; e_aoor[k] = 1;
          end else if (i_a_we && rdw_m[k] == 1) begin
            e_ard[k] = i_a_wdata; e_aperr[k] = i_a_pinj && PAR;
          end else begin
            e_ard[k] = mem_m[k][aa]; e_aperr[k] = bad_m[k][aa] && PAR;
          end
        end
        e_brv[k] = i_b_en; e_boor[k] = 0; e_bperr[k] = 0;
        if (i_b_en) begin
          if (ba >= dep) begin
            e_brd[k] = '0; e_boor[k] = 1;
          end else if (a_wr && ba == aa && rdw_m[k] == 1) begin
            e_brd[k] = i_a_wdata; e_bperr[k] = i_a_pinj && PAR;
          end else begin
            e_brd[k] = mem_m[k][ba]; e_bperr[k] = bad_m[k][ba] && PAR;
          end
        end
        if (a_wr) begin
          mem_m[k][aa] = i_a_wdata;
          bad_m[k][aa] = i_a_pinj;
        end
        if (i_clr) busy_left[k] = dep;
        e_busy[k] = i_clr;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("busy%0d", k),     32'(busy[k]),     32'(e_busy[k]));
      check($sformatf("a_rdata%0d", k),  32'(a_rdata[k]),  32'(e_ard[k]));
      check($sformatf("a_rvalid%0d", k), 32'(a_rvalid[k]), 32'(e_arv[k]));
      check($sformatf("a_oor%0d", k),    32'(a_oor[k]),    32'(e_aoor[k]));
      check($sformatf("a_perr%0d", k),   32'(a_perr[k]),   32'(e_aperr[k]));
      check($sformatf("b_rdata%0d", k),  32'(b_rdata[k]),  32'(e_brd[k]));
      check($sformatf("b_rvalid%0d", k), 32'(b_rvalid[k]), 32'(e_brv[k]));
      check($sformatf("b_oor%0d", k),    32'(b_oor[k]),    32'(e_boor[k]));
      check($sformatf("b_perr%0d", k),   32'(b_perr[k]),   32'(e_bperr[k]));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input bit a_en, input bit a_we, input int unsigned a_addr, input int unsigned wd,
                       input bit pinj, input bit b_en, input int unsigned b_addr, input bit clr);
    i_a_en = a_en; i_a_we = a_we; i_a_addr = AW'(a_addr); i_a_wdata = DW'(wd);
    i_a_pinj = pinj; i_b_en = b_en; i_b_addr = AW'(b_addr); i_clr = clr;
    tick();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n;
    depth_m = '{64, 48};
    rdw_m   = '{0, 1};
    clr_m   = '{10'h000, 10'h1A5};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("rst_busy", 32'(busy[0]), 32'd1);
    rst = 1'b0;
    n = 0;
    do begin
      idle_cycles(1);
      n++;
    end while (busy[0] && n < 200);
    check("clear_len", 32'(n), 32'd64);

    drive(1, 0, 0, 0, 0, 1, 31, 0);
    check("rd0", 32'(a_rdata[0]), 32'h0);
    drive(1, 0, 63, 0, 0, 0, 0, 0);
    check("rd63_oor_small", 32'(a_oor[1]), 32'd1);

    drive(1, 1, 5, 10'h2AB, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 5, 0);
    check("b_rd5", 32'(b_rdata[0]), 32'h2AB);
    check("b_rv5", 32'(b_rvalid[0]), 32'd1);

    drive(1, 1, 7, 10'h2AB, 0, 0, 0, 0);
    drive(1, 1, 7, 10'h155, 0, 1, 7, 0);
    check("rdw_old", 32'(b_rdata[0]), 32'h2AB);
    check("rdw_new", 32'(b_rdata[1]), 32'h155);

    drive(1, 1, 50, 10'h3FF, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 50, 0);
    check("oor_rd", 32'(b_rdata[1]), 32'h0);
    check("oor_flag", 32'(b_oor[1]), 32'd1);

    drive(1, 1, 9, 10'h011, 1, 0, 0, 0);
    drive(1, 0, 9, 0, 0, 0, 0, 0);
    check("perr_inj", 32'(a_perr[0]), 32'(PAR));
    drive(1, 1, 9, 10'h011, 0, 0, 0, 0);
    drive(1, 0, 9, 0, 0, 0, 0, 0);
    check("perr_clean", 32'(a_perr[0]), 32'd0);

    drive(1, 1, 3, 10'h123, 0, 0, 0, 1);
    check("clr_wr_norv", 32'(a_rvalid[0]), 32'd0);
    idle_cycles(64);
    drive(1, 0, 3, 0, 0, 0, 0, 0);
    check("clr_rd3_0", 32'(a_rdata[0]), 32'h0);
    check("clr_rd3_1", 32'(a_rdata[1]), 32'h1A5);

    // Reset pulse in the middle of a clear restarts the full sweep.
    rst = 1'b1; tick(); rst = 1'b0;
    idle_cycles(20);
    rst = 1'b1; tick(); rst = 1'b0;
    n = 0;
    do begin
      idle_cycles(1);
      n++;
    end while (busy[0] && n < 200);
    check("restart_len", 32'(n), 32'd64);

    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 1023),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 63),
            ($urandom_range(0, 149) == 0));
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
